dmem_arbiter: RTL

//  Two-requester arbiter for the single-port data memory in the MEM stage.

---
 rtl/dmem_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Purpose : arbitrate the single-port data memory between the pipeline (cpu) and the
//           debug/program-loader port (dbg); cpu has fixed priority, dbg is forced in
//           after STARVE_LIMIT refused cycles. Load data is returned to its owner only.
// Ports   : clk/reset (sync, active-high); cpu_* and dbg_* request/grant/read-return
//           ports; mem_* drive the data memory, mem_rdata returns 1 cycle after mem_read.
// Latency : grant is combinational in the request cycle, load data valid one cycle later;
//           cpu_stall is asserted whenever the cpu requests and is refused.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } rd_state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    rd_state_t        rd_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             force_dbg;

    // dbg has waited long enough: it beats the cpu this cycle.
    assign force_dbg = dbg_req & (wait_cnt >= LIMIT);

    // Grants are masked during reset so nothing reaches memory while reset is high.
    assign cpu_gnt   = ~reset & cpu_req & ~force_dbg;
    assign dbg_gnt   = ~reset & dbg_req & (force_dbg | ~cpu_req);
    assign cpu_stall = ~reset & cpu_req & ~cpu_gnt;

    assign mem_read  = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);
    assign mem_write = (cpu_gnt &  cpu_we) | (dbg_gnt &  dbg_we);
    assign mem_addr  = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : 32'h0);
    assign mem_wdata = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : 32'h0);

    // Read return steering. Reset also hides a response that was already in flight
    // when reset rose, since rd_state only clears at the following edge.
    assign cpu_rvalid = ~reset & (rd_state == CPU_RD);
    assign dbg_rvalid = ~reset & (rd_state == DBG_RD);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : 32'h0;

    // Read-owner FSM and starvation counter. Next owner depends only on this cycle's
    // grant, so back-to-back loads from either side pipeline without bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= IDLE;
            wait_cnt <= '0;
        end else begin
            if (cpu_gnt & ~cpu_we)
                rd_state <= CPU_RD;
            else if (dbg_gnt & ~dbg_we)
                rd_state <= DBG_RD;
            else
                rd_state <= IDLE;

            if (~dbg_req | dbg_gnt)
                wait_cnt <= '0;
            else if (wait_cnt < LIMIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule
